// File: rtl/score_event_gen_if.sv
// Game-rule engine bus: per-frame bird/pipe geometry in,
// score pulse and game state out.
interface score_event_gen_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic           frame_tick;
  logic           start;
  logic [Y_W-1:0] bird_y;
  logic [X_W-1:0] pipe0_x;
  logic [X_W-1:0] pipe1_x;
  logic [Y_W-1:0] pipe0_gap_y;
  logic [Y_W-1:0] pipe1_gap_y;
  logic           score_inc;
  logic           collision;
  logic           playing;
  logic [1:0]     state;

  modport master (
    output frame_tick, start, bird_y,
    output pipe0_x, pipe1_x,
    output pipe0_gap_y, pipe1_gap_y,
    input  score_inc, collision, playing, state
  );

  modport slave (
    input  frame_tick, start, bird_y,
    input  pipe0_x, pipe1_x,
    input  pipe0_gap_y, pipe1_gap_y,
    output score_inc, collision, playing, state
  );
endinterface

// File: rtl/score_event_gen.sv
// Score-increment and collision engine with IDLE/PLAY/DEAD FSM.
// SCORE_EVENT_INVINCIBLE_EN: pipe collisions ignored, floor only.
module score_event_gen #(
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int BIRD_X    = 160,
  parameter int BIRD_SIZE = 16,
  parameter int PIPE_W    = 40,
  parameter int GAP_H     = 120,
  parameter int SCREEN_H  = 480
) (
  input logic              clk,
  input logic              reset,
  score_event_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DEAD = 2'b10
  } state_t;

  localparam logic [X_W:0] BX  = (X_W+1)'(BIRD_X);
  localparam logic [X_W:0] BXE = (X_W+1)'(BIRD_X + BIRD_SIZE);
  localparam logic [X_W:0] PW  = (X_W+1)'(PIPE_W);
  localparam logic [Y_W:0] BS  = (Y_W+1)'(BIRD_SIZE);
  localparam logic [Y_W:0] GH  = (Y_W+1)'(GAP_H);
  localparam logic [Y_W:0] SH  = (Y_W+1)'(SCREEN_H);

  state_t         st;
  state_t         st_nx;
  logic           start_q;
  logic           rise;
  logic           s0_vld;
  logic [X_W-1:0] p0x;
  logic [X_W-1:0] p1x;
  logic [Y_W-1:0] by;
  logic [Y_W-1:0] g0;
  logic [Y_W-1:0] g1;
  logic [1:0]     prev_passed;
  logic [1:0]     pending;
  logic           score_inc_q;
  logic           collision_q;
  logic           playing_q;

  logic [X_W:0]   p0r;
  logic [X_W:0]   p1r;
  logic [Y_W:0]   bb;
  logic           passed0;
  logic           passed1;
  logic           hpipe0;
  logic           hpipe1;
  logic           vout0;
  logic           vout1;
  logic           ov0;
  logic           ov1;
  logic           floor_hit;
  logic           hit;
  logic           fire;
  logic [2:0]     sum;
  logic [1:0]     sat;

  assign rise = bus.start & ~start_q;

  // Stage-1 geometry tests, all sums one bit wider than operands
  always_comb begin
    p0r       = {1'b0, p0x} + PW;
    p1r       = {1'b0, p1x} + PW;
    bb        = {1'b0, by} + BS;
    passed0   = p0r < BX;
    passed1   = p1r < BX;
    hpipe0    = ({1'b0, p0x} < BXE) && (p0r > BX);
    hpipe1    = ({1'b0, p1x} < BXE) && (p1r > BX);
    vout0     = (by < g0) || (bb > ({1'b0, g0} + GH));
    vout1     = (by < g1) || (bb > ({1'b0, g1} + GH));
    floor_hit = bb >= SH;
`ifdef SCORE_EVENT_INVINCIBLE_EN
    ov0       = 1'b0 & hpipe0 & vout0;
    ov1       = 1'b0 & hpipe1 & vout1;
`else
    ov0       = hpipe0 & vout0;
    ov1       = hpipe1 & vout1;
`endif
    hit       = floor_hit | ov0 | ov1;
    fire      = s0_vld && (st == PLAY);
    sum       = {1'b0, pending}
              + {2'b0, passed0 & ~prev_passed[0]}
              + {2'b0, passed1 & ~prev_passed[1]};
    sat       = (sum > 3'd3) ? 2'd3 : sum[1:0];
  end

  // Game state next-state decode
  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (rise) st_nx = PLAY;
      PLAY:    if (fire && hit) st_nx = DEAD;
      DEAD:    if (rise) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // Game state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else       st <= st_nx;
  end

  // Stage 0 capture, scoring pipeline and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q     <= 1'b0;
      s0_vld      <= 1'b0;
      p0x         <= '0;
      p1x         <= '0;
      by          <= '0;
      g0          <= '0;
      g1          <= '0;
      prev_passed <= 2'b11;
      pending     <= 2'd0;
      score_inc_q <= 1'b0;
      collision_q <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      start_q     <= bus.start;
      collision_q <= st_nx == DEAD;
      playing_q   <= st_nx == PLAY;
      s0_vld      <= bus.frame_tick && (st == PLAY);
      if (bus.frame_tick && (st == PLAY)) begin
        p0x <= bus.pipe0_x;
        p1x <= bus.pipe1_x;
        by  <= bus.bird_y;
        g0  <= bus.pipe0_gap_y;
        g1  <= bus.pipe1_gap_y;
      end
      if (st == IDLE && rise) begin
        prev_passed <= 2'b11;
        pending     <= 2'd0;
        score_inc_q <= 1'b0;
      end else if (st != PLAY) begin
        pending     <= 2'd0;
        score_inc_q <= 1'b0;
      end else if (fire) begin
        prev_passed <= {passed1, passed0};
        if (hit) begin
          pending     <= 2'd0;
          score_inc_q <= 1'b0;
        end else if (sat != 2'd0) begin
          pending     <= sat - 2'd1;
          score_inc_q <= 1'b1;
        end else begin
          pending     <= 2'd0;
          score_inc_q <= 1'b0;
        end
      end else if (pending != 2'd0) begin
        pending     <= pending - 2'd1;
        score_inc_q <= 1'b1;
      end else begin
        score_inc_q <= 1'b0;
      end
    end
  end

  assign bus.score_inc = score_inc_q;
  assign bus.collision = collision_q;
  assign bus.playing   = playing_q;
  assign bus.state     = st;

endmodule

// File: tb/tb_score_event_gen.sv
// Scoreboard bench for score_event_gen: expected pulse cycles
// are queued per frame and matched every cycle.
module tb_score_event_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int   mst = 0;
  logic [1:0] mprev = 2'b11;
  int   sb[$];
  int   last_sched = 0;

  score_event_gen_if bus ();

  score_event_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Per-cycle score_inc comparison against the scoreboard
  always @(negedge clk) begin
    logic exp;
    exp = (sb.size() > 0) && (sb[0] == cyc);
    if (exp) void'(sb.pop_front());
    check("score_inc", bus.score_inc, exp);
  end

  function automatic logic m_passed(int x);
    return (x + 40) < 160;
  endfunction

  function automatic logic m_ov(int x, int g, int y);
`ifdef SCORE_EVENT_INVINCIBLE_EN
    return 1'b0;
`else
    return (x < 176) && (x + 40 > 160) &&
           ((y < g) || (y + 16 > g + 120));
`endif
  endfunction

  task automatic drive_frame(int x0, int x1, int g0, int g1,
                             int y, output int t);
    logic p0, p1, h;
    int   n, nxt;
    @(posedge clk); #1;
    bus.pipe0_x     = x0[9:0];
    bus.pipe1_x     = x1[9:0];
    bus.pipe0_gap_y = g0[8:0];
    bus.pipe1_gap_y = g1[8:0];
    bus.bird_y      = y[8:0];
    bus.frame_tick  = 1'b1;
    t = cyc;
    if (mst == 1) begin
      p0 = m_passed(x0);
      p1 = m_passed(x1);
      h  = (y + 16 >= 480) || m_ov(x0, g0, y) || m_ov(x1, g1, y);
      n  = int'(p0 && !mprev[0]) + int'(p1 && !mprev[1]);
      mprev = {p1, p0};
      if (h) begin
        while (sb.size() > 0 && sb[$] >= t + 2) void'(sb.pop_back());
        last_sched = 0;
        mst = 2;
      end else begin
        for (int i = 0; i < n; i++) begin
          nxt = (last_sched + 1 > t + 2 + i) ? last_sched + 1
                                              : t + 2 + i;
          sb.push_back(nxt);
          last_sched = nxt;
        end
      end
    end
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
  endtask

  task automatic expect_state(int t);
    do @(negedge clk); while (cyc < t);
    check("state", bus.state, mst);
    check("collision", bus.collision, mst == 2);
    check("playing", bus.playing, mst == 1);
  endtask

  task automatic press_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    if (mst == 0) begin
      mst = 1;
      mprev = 2'b11;
    end else if (mst == 2) begin
      mst = 0;
    end
    check("st_start", bus.state, mst);
    check("col_start", bus.collision, mst == 2);
    check("play_start", bus.playing, mst == 1);
  endtask

  task automatic to_play();
    for (int i = 0; i < 3 && mst != 1; i++) press_start();
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    bus.frame_tick  = 1'b0;
    bus.start       = 1'b0;
    bus.bird_y      = '0;
    bus.pipe0_x     = '0;
    bus.pipe1_x     = '0;
    bus.pipe0_gap_y = '0;
    bus.pipe1_gap_y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", bus.state, 0);
    check("rst_col", bus.collision, 0);
    check("rst_play", bus.playing, 0);
    check("rst_inc", bus.score_inc, 0);
    reset = 1'b0;
    idle(2);

    // frame in IDLE is ignored
    drive_frame(119, 600, 150, 150, 200, t);
    expect_state(t + 2);

    press_start();
    drive_frame(130, 600, 150, 150, 200, t); idle(4);
    drive_frame(121, 600, 150, 150, 200, t); idle(4);
    drive_frame(119, 600, 150, 150, 200, t); idle(4);

    // two points in one frame
    drive_frame(300, 300, 150, 150, 200, t); idle(4);
    drive_frame(119, 100, 150, 150, 200, t); idle(6);

    // pipe collision (ignored when invincible)
    drive_frame(300, 600, 100, 150, 50, t); idle(3);
    drive_frame(150, 600, 100, 150, 50, t);
    expect_state(t + 2);
    idle(3);
    press_start();
    to_play();

    // floor collision
    drive_frame(600, 600, 150, 150, 470, t);
    expect_state(t + 2);
    idle(3);
    press_start();
    to_play();

    // recycle 0 -> 600 earns nothing, rise again does
    drive_frame(0, 600, 150, 150, 200, t); idle(4);
    drive_frame(600, 600, 150, 150, 200, t); idle(4);
    drive_frame(0, 600, 150, 150, 200, t); idle(4);

    // reset during two-pulse drain
    drive_frame(300, 300, 150, 150, 200, t); idle(4);
    drive_frame(119, 100, 150, 150, 200, t);
    do @(negedge clk); while (cyc < t + 2);
    #1 reset = 1'b1;
    sb.delete();
    last_sched = 0;
    mst = 0;
    mprev = 2'b11;
    #1;
    check("inc_at_rst", bus.score_inc, 0);
    check("st_at_rst", bus.state, 0);
    idle(3);
    reset = 1'b0;
    idle(8);
    check("st_after_rst", bus.state, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
